// File: rtl/alu_reservation_station.sv
// Four-entry ALU reservation station: rename-side capture, CDB wakeup with
// same-cycle bypass, lowest-index select and a registered valid/ready issue slot.

module alu_rs_entry #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ROB     = 2
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           flush,
  input  logic           wr,
  input  logic           free,
  input  logic [WIDTH:0] value1,
  input  logic [WIDTH:0] value2,
  input  logic           ready1,
  input  logic           ready2,
  input  logic [ROB:0]   rob1,
  input  logic [ROB:0]   rob2,
  input  logic [ROB:0]   destRob,
  input  logic [A_WIDTH:0] aluCntrl,
  input  logic           cdbValid,
  input  logic [ROB:0]   cdbTag,
  input  logic [WIDTH:0] cdbValue,
  output logic           busy,
  output logic           rdy1,
  output logic           rdy2,
  output logic [WIDTH:0] val1,
  output logic [WIDTH:0] val2,
  output logic [A_WIDTH:0] cntrl,
  output logic [ROB:0]   dest
);
  logic [ROB:0] tag1, tag2;
  logic byp1, byp2, wake1, wake2;

  // Incoming operands can be satisfied by the CDB in the very cycle they are written.
  assign byp1  = !ready1 && cdbValid && (rob1 == cdbTag);
  assign byp2  = !ready2 && cdbValid && (rob2 == cdbTag);
  assign wake1 = busy && !rdy1 && cdbValid && (tag1 == cdbTag);
  assign wake2 = busy && !rdy2 && cdbValid && (tag2 == cdbTag);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy  <= 1'b0;
      rdy1  <= 1'b0;
      rdy2  <= 1'b0;
      val1  <= '0;
      val2  <= '0;
      tag1  <= '0;
      tag2  <= '0;
      cntrl <= '0;
      dest  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (wr) begin
      busy  <= 1'b1;
      rdy1  <= ready1 | byp1;
      rdy2  <= ready2 | byp2;
      val1  <= byp1 ? cdbValue : value1;
      val2  <= byp2 ? cdbValue : value2;
      tag1  <= rob1;
      tag2  <= rob2;
      cntrl <= aluCntrl;
      dest  <= destRob;
    end else begin
      if (free) busy <= 1'b0;
      if (wake1) begin
        rdy1 <= 1'b1;
        val1 <= cdbValue;
      end
      if (wake2) begin
        rdy2 <= 1'b1;
        val2 <= cdbValue;
      end
    end
  end
endmodule

module alu_reservation_station #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ALU     = 3,
  parameter int ROB     = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [ALU:0]     ALURequests,
  input  logic [WIDTH:0]   value1,
  input  logic [WIDTH:0]   value2,
  input  logic             ready1,
  input  logic             ready2,
  input  logic [ROB:0]     rob1,
  input  logic [ROB:0]     rob2,
  input  logic [ROB:0]     destRob,
  input  logic [A_WIDTH:0] aluCntrl,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbTag,
  input  logic [WIDTH:0]   cdbValue,
  input  logic             flush,
  input  logic             aluReady,
  output logic [ALU:0]     ALUBusyVector,
  output logic             issueValid,
  output logic [WIDTH:0]   issueOp1,
  output logic [WIDTH:0]   issueOp2,
  output logic [A_WIDTH:0] issueCntrl,
  output logic [ROB:0]     issueRob,
  output logic             writeConflict
);
  logic [ALU:0]              busy, rdy1, rdy2, elig, grant, wr_en, free;
  logic [ALU:0][WIDTH:0]     val1, val2;
  logic [ALU:0][A_WIDTH:0]   cntrl;
  logic [ALU:0][ROB:0]       dest;
  logic                      req_ok, conflict, load;
  logic [WIDTH:0]            sel_op1, sel_op2;
  logic [A_WIDTH:0]          sel_cntrl;
  logic [ROB:0]              sel_dest;

  // Busy is the registered view, so an entry freed this cycle still conflicts.
  assign req_ok   = $onehot(ALURequests) && ((ALURequests & busy) == '0);
  assign conflict = (|ALURequests) && !req_ok;
  assign wr_en    = (req_ok && !flush) ? ALURequests : '0;
  assign elig     = busy & rdy1 & rdy2;
  assign load     = (!issueValid || aluReady) && (|elig) && !flush;
  assign free     = load ? grant : '0;
  assign ALUBusyVector = busy;

  for (genvar i = 0; i <= ALU; i++) begin : g_ent
    alu_rs_entry #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH), .ROB(ROB)) u_ent (
      .clk      (clk),
      .resetN   (resetN),
      .flush    (flush),
      .wr       (wr_en[i]),
      .free     (free[i]),
      .value1   (value1),
      .value2   (value2),
      .ready1   (ready1),
      .ready2   (ready2),
      .rob1     (rob1),
      .rob2     (rob2),
      .destRob  (destRob),
      .aluCntrl (aluCntrl),
      .cdbValid (cdbValid),
      .cdbTag   (cdbTag),
      .cdbValue (cdbValue),
      .busy     (busy[i]),
      .rdy1     (rdy1[i]),
      .rdy2     (rdy2[i]),
      .val1     (val1[i]),
      .val2     (val2[i]),
      .cntrl    (cntrl[i]),
      .dest     (dest[i])
    );
  end

  // Lowest-index eligible entry wins; grant is one-hot so the mux is a plain OR.
  always_comb begin
    grant     = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    sel_cntrl = '0;
    sel_dest  = '0;
    for (int i = 0; i <= ALU; i++) begin
      if (elig[i] && grant == '0) grant[i] = 1'b1;
    end
    for (int i = 0; i <= ALU; i++) begin
      if (grant[i]) begin
        sel_op1   = sel_op1   | val1[i];
        sel_op2   = sel_op2   | val2[i];
        sel_cntrl = sel_cntrl | cntrl[i];
        sel_dest  = sel_dest  | dest[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      issueValid    <= 1'b0;
      issueOp1      <= '0;
      issueOp2      <= '0;
      issueCntrl    <= '0;
      issueRob      <= '0;
      writeConflict <= 1'b0;
    end else begin
      if (conflict) writeConflict <= 1'b1;
      if (flush) begin
        issueValid <= 1'b0;
      end else if (load) begin
        issueValid <= 1'b1;
        issueOp1   <= sel_op1;
        issueOp2   <= sel_op2;
        issueCntrl <= sel_cntrl;
        issueRob   <= sel_dest;
      end else if (aluReady) begin
        issueValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station; expected issues go into a
// scoreboard queue that a negedge monitor drains on every valid/ready transfer.

module tb_alu_reservation_station;
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  cntrl;
    logic [2:0]  rob;
  } iss_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic [3:0]  ALURequests;
  logic [31:0] value1, value2, cdbValue;
  logic        ready1, ready2, cdbValid, flush, aluReady;
  logic [2:0]  rob1, rob2, destRob, cdbTag;
  logic [3:0]  aluCntrl;
  logic [3:0]  ALUBusyVector;
  logic        issueValid, writeConflict;
  logic [31:0] issueOp1, issueOp2;
  logic [3:0]  issueCntrl;
  logic [2:0]  issueRob;

  iss_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu_reservation_station dut (
    .clk(clk), .resetN(resetN), .ALURequests(ALURequests),
    .value1(value1), .value2(value2), .ready1(ready1), .ready2(ready2),
    .rob1(rob1), .rob2(rob2), .destRob(destRob), .aluCntrl(aluCntrl),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue),
    .flush(flush), .aluReady(aluReady), .ALUBusyVector(ALUBusyVector),
    .issueValid(issueValid), .issueOp1(issueOp1), .issueOp2(issueOp2),
    .issueCntrl(issueCntrl), .issueRob(issueRob), .writeConflict(writeConflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input logic [3:0] req, input logic [31:0] v1, input logic r1,
                      input logic [2:0] t1, input logic [31:0] v2, input logic r2,
                      input logic [2:0] t2, input logic [2:0] d, input logic [3:0] c);
    ALURequests = req; value1 = v1; ready1 = r1; rob1 = t1;
    value2 = v2; ready2 = r2; rob2 = t2; destRob = d; aluCntrl = c;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic [2:0] r);
    iss_t e;
    e.op1 = a; e.op2 = b; e.cntrl = c; e.rob = r;
    sb.push_back(e);
  endtask

  // A transfer happens at the next posedge whenever valid and ready are both high now.
  always @(negedge clk) begin
    if (resetN && issueValid && aluReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: rob=%0d op1=%0h with empty scoreboard", issueRob, issueOp1);
      end else begin
        iss_t e;
        e = sb.pop_front();
        chk("issue_op1", issueOp1, e.op1);
        chk("issue_op2", issueOp2, e.op2);
        chk("issue_cntrl", {28'd0, issueCntrl}, {28'd0, e.cntrl});
        chk("issue_rob", {29'd0, issueRob}, {29'd0, e.rob});
      end
    end
  end

  initial begin
    resetN = 1'b0; flush = 1'b0; aluReady = 1'b0;
    cdbValid = 1'b0; cdbTag = '0; cdbValue = '0;
    setw(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_busy", {28'd0, ALUBusyVector}, 0);
    chk("rst_valid", {31'd0, issueValid}, 0);
    chk("rst_op1", issueOp1, 0);
    chk("rst_conflict", {31'd0, writeConflict}, 0);
    resetN = 1'b1;
    step();

    // Basic two-edge latency
    aluReady = 1'b1;
    setw(4'b0001, 5, 1, 0, 7, 1, 0, 3, 4'h0);
    push(5, 7, 4'h0, 3);
    step();
    ALURequests = '0;
    chk("t1_busy_e1", {28'd0, ALUBusyVector}, 4'b0001);
    chk("t1_valid_e1", {31'd0, issueValid}, 0);
    step();
    chk("t1_valid_e2", {31'd0, issueValid}, 1);
    chk("t1_busy_e2", {28'd0, ALUBusyVector}, 4'b0000);
    step();
    chk("t1_drained", {31'd0, issueValid}, 0);

    // CDB wakeup of operand 2
    setw(4'b0010, 1, 1, 0, 0, 0, 6, 4, 4'h2);
    push(1, 32'h10, 4'h2, 4);
    step();
    ALURequests = '0;
    chk("t2_busy", {28'd0, ALUBusyVector}, 4'b0010);
    step();
    step();
    chk("t2_wait", {31'd0, issueValid}, 0);
    cdbValid = 1'b1; cdbTag = 6; cdbValue = 32'h10;
    step();
    cdbValid = 1'b0;
    chk("t2_capture", {31'd0, issueValid}, 0);
    step();
    chk("t2_issue", {31'd0, issueValid}, 1);
    chk("t2_op2", issueOp2, 32'h10);
    step();

    // Same-cycle bypass on write
    setw(4'b0100, 0, 0, 2, 3, 1, 0, 5, 4'h1);
    cdbValid = 1'b1; cdbTag = 2; cdbValue = 32'hAA;
    push(32'hAA, 3, 4'h1, 5);
    step();
    ALURequests = '0; cdbValid = 1'b0;
    chk("t3_busy", {28'd0, ALUBusyVector}, 4'b0100);
    step();
    chk("t3_issue", {31'd0, issueValid}, 1);
    chk("t3_op1", issueOp1, 32'hAA);
    step();

    // Back-pressure: entry 0 held, entry 2 follows
    aluReady = 1'b0;
    setw(4'b0001, 32'h11, 1, 0, 32'h12, 1, 0, 1, 4'h3);
    push(32'h11, 32'h12, 4'h3, 1);
    step();
    setw(4'b0100, 32'h33, 1, 0, 32'h44, 1, 0, 2, 4'h4);
    push(32'h33, 32'h44, 4'h4, 2);
    step();
    ALURequests = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_valid", {31'd0, issueValid}, 1);
      chk("t4_hold_op1", issueOp1, 32'h11);
      chk("t4_hold_busy", {28'd0, ALUBusyVector}, 4'b0100);
      step();
    end
    aluReady = 1'b1;
    step();
    chk("t4_second_op1", issueOp1, 32'h33);
    chk("t4_second_busy", {28'd0, ALUBusyVector}, 4'b0000);
    step();
    chk("t4_empty", {31'd0, issueValid}, 0);

    // Fill all four, conflicting write must not disturb entry 3
    aluReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setw(4'(1 << i), 32'h100 + i, 1, 0, 0, 0, 7, 3'(i), 4'(i));
      push(32'h100 + i, 32'h77, 4'(i), 3'(i));
      step();
    end
    chk("t5_full", {28'd0, ALUBusyVector}, 4'b1111);
    chk("t5_no_conflict", {31'd0, writeConflict}, 0);
    setw(4'b1000, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 7, 4'hF);
    step();
    ALURequests = '0;
    chk("t5_conflict", {31'd0, writeConflict}, 1);
    chk("t5_still_idle", {31'd0, issueValid}, 0);
    aluReady = 1'b1;
    cdbValid = 1'b1; cdbTag = 7; cdbValue = 32'h77;
    step();
    cdbValid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("t5_drained_busy", {28'd0, ALUBusyVector}, 0);

    // Flush with three busy entries and a held issue
    aluReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setw(4'(1 << i), 32'h200 + i, 1, 0, 1, 1, 0, 3'(i), 4'h5);
      step();
    end
    ALURequests = '0;
    chk("t6_pre_busy", {28'd0, ALUBusyVector}, 4'b1110);
    chk("t6_pre_valid", {31'd0, issueValid}, 1);
    flush = 1'b1;
    setw(4'b0001, 1, 1, 0, 1, 1, 0, 0, 0);
    step();
    flush = 1'b0;
    ALURequests = '0;
    chk("t6_busy", {28'd0, ALUBusyVector}, 0);
    chk("t6_valid", {31'd0, issueValid}, 0);
    chk("t6_conflict_kept", {31'd0, writeConflict}, 1);
    step();
    chk("t6_no_revive", {31'd0, issueValid}, 0);

    // Mid-cycle asynchronous reset
    setw(4'b0001, 9, 1, 0, 9, 1, 0, 1, 0);
    step();
    setw(4'b0010, 8, 1, 0, 8, 1, 0, 2, 0);
    step();
    ALURequests = '0;
    chk("t7_pre_valid", {31'd0, issueValid}, 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("t7_busy", {28'd0, ALUBusyVector}, 0);
    chk("t7_valid", {31'd0, issueValid}, 0);
    chk("t7_op1", issueOp1, 0);
    chk("t7_rob", {29'd0, issueRob}, 0);
    chk("t7_conflict", {31'd0, writeConflict}, 0);
    resetN = 1'b1;
    step();

    // Multi-hot request is a conflict and writes nothing
    setw(4'b0011, 1, 1, 0, 1, 1, 0, 0, 0);
    step();
    ALURequests = '0;
    chk("t8_multi_conflict", {31'd0, writeConflict}, 1);
    chk("t8_multi_busy", {28'd0, ALUBusyVector}, 0);

    step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Four-entry reservation station for the integer ALU, directly downstream of the rename stage.
- Each cycle, captures at most one renamed ALU instruction into the entry selected by the rename arbiter's one-hot request vector.
- Snoops the common data bus (CDB) to wake waiting operands, then issues one ready instruction per cycle to the ALU through a registered valid/ready interface.
- Drives the busy vector back to the rename-stage arbiter.

Parameters:
- WIDTH, 31, MSB index of operand values (32-bit data).
- A_WIDTH, 3, MSB index of ALU control field.
- ALU, 3, MSB index of entry vector (ALU+1 = 4 entries).
- ROB, 2, MSB index of ROB tag (8-entry ROB).

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- ALURequests  in  ALU+1  one-hot entry write select from rename arbiter; all-zero means no write.
- value1, value2  in  WIDTH+1  source operand value, or don't-care when not ready.
- ready1, ready2  in  1  operand value valid.
- rob1, rob2  in  ROB+1  producing ROB tag when operand not ready.
- destRob  in  ROB+1  ROB tag of the instruction being written.
- aluCntrl  in  A_WIDTH+1  ALU operation.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  ROB+1  CDB result tag.
- cdbValue  in  WIDTH+1  CDB result value.
- flush  in  1  mispredict/redirect; kill all entries.
- aluReady  in  1  ALU accepts the issued instruction this cycle.
- ALUBusyVector  out  ALU+1  per-entry occupied flag.
- issueValid  out  1  issue register holds an instruction.
- issueOp1, issueOp2  out  WIDTH+1  operands.
- issueCntrl  out  A_WIDTH+1  ALU operation.
- issueRob  out  ROB+1  destination tag.
- writeConflict  out  1  sticky: a write targeted a busy entry.

Behaviour:
- Reset state (asynchronous, resetN low): all entries invalid, ALUBusyVector=0, issueValid=0, issue data=0, writeConflict=0.
- Entry fields: busy, rdy1, rdy2, val1, val2, tag1, tag2, cntrl, dest.
- Write: if ALURequests[i] is set and entry i is free, load the entry at the next edge.
  - If readyN=0, cdbValid=1 and robN==cdbTag in the same cycle, store cdbValue and mark the operand ready (same-cycle bypass).
- More than one request bit set, or the target entry busy: no write; set writeConflict (cleared only by reset).
- Wakeup: every busy entry with an operand not ready and a tag equal to cdbTag (cdbValid=1) captures cdbValue; that operand is ready next cycle.
- Selection (combinational, from registered state): an entry is eligible when busy && rdy1 && rdy2. The lowest-index eligible entry wins.
- Issue register (valid/ready):
  - Load when the register is empty (issueValid=0) or draining this cycle (aluReady=1), and some entry is eligible.
  - The winning entry is freed in the same edge.
  - With no eligible entry, issueValid clears after draining.
  - Contents are held stable while issueValid=1 and aluReady=0.
- Latency:
  - Write with both operands ready, empty issue register: issueValid on the 2nd edge after the write cycle (write edge, then issue edge).
  - CDB wakeup: issueValid one edge after the capture edge.
- Same-cycle free and write: an entry freed by issue at edge k reports busy=0 after edge k; a write to it is accepted from the cycle after.
- Simultaneous write and CDB for the same tag: handled by the bypass above, so no lost wakeup.
- Flush (synchronous, highest priority):
  - Clears all busy bits and issueValid at the next edge.
  - Ignores a same-cycle write and issue.
  - writeConflict is unaffected.
- Full: all four busy; the rename arbiter sees ALUBusyVector=4'b1111; any write sets writeConflict.
- Tags are compared at full ROB+1 width; no wrap handling is needed (tags are unique while in flight).
- Mid-operation asynchronous reset returns to the reset state immediately.

Test Plan:
- Write entry 0 (ALURequests=4'b0001, ready1=ready2=1, values 5 and 7, aluCntrl=4'h0, destRob=3), aluReady=1 -> ALUBusyVector=4'b0001 after edge 1; issueValid=1, issueOp1=5, issueOp2=7, issueRob=3 after edge 2; busy clears.
- Write entry 1 with ready2=0, rob2=6; CDB tag 6 value 0x10 three cycles later -> no issue before the CDB; issueOp2=0x10 one edge after capture.
- Bypass: write with rob1=2, ready1=0 while cdbValid=1, cdbTag=2, cdbValue=0xAA -> entry stores 0xAA; issues on the next edge with issueOp1=0xAA.
- Back-pressure: entries 0 and 2 both ready, aluReady=0 for 3 cycles -> entry 0 issued and held stable; entry 2 issues one edge after aluReady=1.
- Fill all four entries, then write to entry 3 -> writeConflict=1, entry 3 contents unchanged.
- Flush with 3 busy entries and issueValid=1 -> after the edge, ALUBusyVector=0 and issueValid=0; assert resetN low mid-stream -> all outputs 0 immediately.
